iot_out_dispatch: RTL and testbench

Output-direction companion to the CPU input multiplexer. Decodes output-type IOT instructions and captures AC in F2. Drives a registered data bus, a one-hot device select and a stretched write strobe to the serial, memory-management and RK8E disk peripherals. Holds a CPU stall until the selected device acknowledges or a timeout expires.

---
 rtl/iot_out_dispatch_pkg.sv | 49 ++++
 rtl/iot_out_decode.sv | 42 ++++
 rtl/iot_out_dispatch.sv | 145 ++++++++++++++
 tb/tb_iot_out_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_out_dispatch_pkg.sv
// Shared constants and types for the output IOT dispatcher.
// Opcodes, device index, FSM encoding and CPU major-state codes.
package iot_out_dispatch_pkg;

  localparam logic [4:0] F1 = 5'b00001;
  localparam logic [4:0] F2 = 5'b00010;
  localparam logic [4:0] F3 = 5'b00100;

  localparam logic [11:0] OP_SER_A  = 12'o6044;
  localparam logic [11:0] OP_SER_B  = 12'o6046;
  localparam logic [11:0] OP_DSK_A  = 12'o6743;
  localparam logic [11:0] OP_DSK_B  = 12'o6744;
  localparam logic [11:0] OP_DSK_C  = 12'o6746;
  localparam logic [11:0] OP_DSK_D  = 12'o6747;

  localparam logic [5:0] MMU_HI     = 6'o62;
  localparam logic [2:0] MMU_OP_MIN = 3'o1;
  localparam logic [2:0] MMU_OP_MAX = 3'o3;

  typedef enum logic [1:0] {
    DEV_NONE,
    DEV_SERIAL,
    DEV_MEM,
    DEV_DISK
  } dev_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_ACK,
    S_DONE
  } st_e;

  // select vector order: {serial, mem, disk}
  function automatic logic [2:0] sel_of(
    input dev_e d
  );
    logic [2:0] s;
    s = 3'b000;
    unique case (d)
      DEV_SERIAL: s = 3'b100;
      DEV_MEM:    s = 3'b010;
      DEV_DISK:   s = 3'b001;
      default:    s = 3'b000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/iot_out_decode.sv
// Instruction to output-device decoder.
// Purely combinational; unmatched codes give DEV_NONE.
module iot_out_decode
  import iot_out_dispatch_pkg::*;
(
  input  logic [0:11] instruction,
  output dev_e        dev
);

  logic is_ser;
  logic is_mem;
  logic is_dsk;
  logic [2:0] mmu_op;

  assign mmu_op = instruction[9:11];

  assign is_ser =
    (instruction == OP_SER_A) ||
    (instruction == OP_SER_B);

  assign is_mem =
    (instruction[0:5] == MMU_HI) &&
    (mmu_op >= MMU_OP_MIN) &&
    (mmu_op <= MMU_OP_MAX);

  assign is_dsk =
    (instruction == OP_DSK_A) ||
    (instruction == OP_DSK_B) ||
    (instruction == OP_DSK_C) ||
    (instruction == OP_DSK_D);

  always_comb begin
    dev = DEV_NONE;
    unique case (1'b1)
      is_ser:  dev = DEV_SERIAL;
      is_mem:  dev = DEV_MEM;
      is_dsk:  dev = DEV_DISK;
      default: dev = DEV_NONE;
    endcase
  end

endmodule

// File: rtl/iot_out_dispatch.sv
// Output IOT dispatcher: latches AC at F2, strobes the
// selected peripheral and stalls the CPU until ack/timeout.
module iot_out_dispatch
  import iot_out_dispatch_pkg::*;
#(
  parameter int STROBE_LEN = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  state,
  input  logic [0:11] instruction,
  input  logic [0:11] ac,
  input  logic        ack_serial,
  input  logic        ack_mem,
  input  logic        ack_disk,
  output logic [0:11] out_bus,
  output logic [0:5]  dev_op,
  output logic        sel_serial,
  output logic        sel_mem,
  output logic        sel_disk,
  output logic        strobe,
  output logic        busy,
  output logic        iot_timeout
);

  localparam int CW = 8;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT - 1);

  dev_e dev;

  st_e           st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ack_seen, ack_seen_n;
  logic [2:0]    sel, sel_n;
  logic [0:11]   bus_n;
  logic [0:5]    op_n;
  logic          strobe_n;
  logic          busy_n;
  logic          tmo_n;
  logic          ack_q;
  logic          start;

  iot_out_decode u_dec (
    .instruction (instruction),
    .dev         (dev)
  );

  assign sel_serial = sel[2];
  assign sel_mem    = sel[1];
  assign sel_disk   = sel[0];

  // only the selected device may complete the transfer
  assign ack_q =
    (sel[2] & ack_serial) |
    (sel[1] & ack_mem)    |
    (sel[0] & ack_disk);

  assign start =
    (state == F2) && (dev != DEV_NONE);

  always_comb begin
    st_n       = st;
    cnt_n      = cnt;
    ack_seen_n = ack_seen;
    sel_n      = sel;
    bus_n      = out_bus;
    op_n       = dev_op;
    strobe_n   = strobe;
    busy_n     = busy;
    tmo_n      = iot_timeout;
    unique case (st)
      S_IDLE: begin
        if (start) begin
          bus_n      = ac;
          op_n       = instruction[6:11];
          sel_n      = sel_of(dev);
          strobe_n   = 1'b1;
          busy_n     = 1'b1;
          cnt_n      = CNT_INIT;
          ack_seen_n = 1'b0;
          st_n       = S_STROBE;
        end
      end
      S_STROBE: begin
        if (ack_q) ack_seen_n = 1'b1;
        if (cnt == '0) begin
          strobe_n = 1'b0;
          cnt_n    = '0;
          st_n     = (ack_seen || ack_q) ?
                     S_DONE : S_WAIT_ACK;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_WAIT_ACK: begin
        // ack on the final cycle beats the timeout
        if (ack_q) begin
          st_n = S_DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_n = 1'b1;
          st_n  = S_DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        busy_n     = 1'b0;
        sel_n      = 3'b000;
        cnt_n      = '0;
        ack_seen_n = 1'b0;
        st_n       = S_IDLE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_IDLE;
      cnt         <= '0;
      ack_seen    <= 1'b0;
      sel         <= 3'b000;
      out_bus     <= '0;
      dev_op      <= '0;
      strobe      <= 1'b0;
      busy        <= 1'b0;
      iot_timeout <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= cnt_n;
      ack_seen    <= ack_seen_n;
      sel         <= sel_n;
      out_bus     <= bus_n;
      dev_op      <= op_n;
      strobe      <= strobe_n;
      busy        <= busy_n;
      iot_timeout <= tmo_n;
    end
  end

endmodule

// File: tb/tb_iot_out_dispatch.sv
// Self-checking bench for iot_out_dispatch.
// Transaction-level timing model with randomized acks.
module tb_iot_out_dispatch;
  import iot_out_dispatch_pkg::*;

  localparam int L = 2;
  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  state = 5'd0;
  logic [11:0] instruction = 12'o7000;
  logic [11:0] ac = 12'd0;
  logic        ack_serial = 1'b0;
  logic        ack_mem = 1'b0;
  logic        ack_disk = 1'b0;
  logic [11:0] out_bus;
  logic [5:0]  dev_op;
  logic        sel_serial;
  logic        sel_mem;
  logic        sel_disk;
  logic        strobe;
  logic        busy;
  logic        iot_timeout;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [11:0] exp_out = '0;
  logic [5:0]  exp_op = '0;
  bit          exp_tmo = 1'b0;

  iot_out_dispatch #(
    .STROBE_LEN (L),
    .TIMEOUT    (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .instruction (instruction),
    .ac          (ac),
    .ack_serial  (ack_serial),
    .ack_mem     (ack_mem),
    .ack_disk    (ack_disk),
    .out_bus     (out_bus),
    .dev_op      (dev_op),
    .sel_serial  (sel_serial),
    .sel_mem     (sel_mem),
    .sel_disk    (sel_disk),
    .strobe      (strobe),
    .busy        (busy),
    .iot_timeout (iot_timeout)
  );

  always #5 clk = ~clk;

  // 0 none, 1 serial, 2 mem, 3 disk, from octal digits
  function automatic int model_dev(
    input logic [11:0] i
  );
    int d0, d1, d2, d3;
    d0 = int'(i[11:9]);
    d1 = int'(i[8:6]);
    d2 = int'(i[5:3]);
    d3 = int'(i[2:0]);
    if (d0 != 6) return 0;
    if (d1 == 0 && d2 == 4 &&
        (d3 == 4 || d3 == 6)) return 1;
    if (d1 == 2 && d3 >= 1 && d3 <= 3) return 2;
    if (d1 == 7 && d2 == 4 &&
        (d3 == 3 || d3 == 4 ||
         d3 == 6 || d3 == 7)) return 3;
    return 0;
  endfunction

  function automatic logic [11:0] rand_dev_instr();
    logic [11:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom_range(0, 1) ? 12'o6046
                                  : 12'o6044;
      1: r = {3'o6, 3'o2,
              3'($urandom_range(0, 7)),
              3'($urandom_range(1, 3))};
      default: begin
        case ($urandom_range(0, 3))
          0: r = 12'o6743;
          1: r = 12'o6744;
          2: r = 12'o6746;
          default: r = 12'o6747;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    state = F1;
    instruction = 12'o7000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (out_bus !== 12'd0)
      $display("FAIL reset_out_bus got %o want 0",
               out_bus);
    else pass_cnt++;
    total_cnt++;
    if (dev_op !== 6'd0)
      $display("FAIL reset_dev_op got %o want 0",
               dev_op);
    else pass_cnt++;
    total_cnt++;
    if ({sel_serial, sel_mem, sel_disk,
         strobe, busy, iot_timeout} !== 6'd0)
      $display("FAIL reset_flags got %b want 0",
               {sel_serial, sel_mem, sel_disk,
                strobe, busy, iot_timeout});
    else pass_cnt++;
    exp_out = '0;
    exp_op = '0;
    exp_tmo = 1'b0;
  endtask

  // k: cycle of first qualifying ack after capture
  // (cycle 0 = first strobe cycle), -1 for never
  task automatic run_iot(
    input string       nm,
    input logic [11:0] ins,
    input logic [11:0] acv,
    input int          k,
    input bit          hold,
    input bit          foreign,
    input bit          spur
  );
    int d, exp_len, ncyc;
    int busy_err, strobe_err, sel_err;
    bit tmo, q, f;
    logic [2:0] esel, obs;
    d = model_dev(ins);
    esel = 3'b100 >> (d - 1);
    if (k < 0 || k > L + T - 1) begin
      exp_len = L + T + 1;
      tmo = 1'b1;
    end else if (k < L) begin
      exp_len = L + 1;
      tmo = 1'b0;
    end else begin
      exp_len = k + 2;
      tmo = 1'b0;
    end
    busy_err = 0;
    strobe_err = 0;
    sel_err = 0;
    ncyc = L + T + 4;
    @(negedge clk);
    state = F2;
    instruction = ins;
    ac = acv;
    ack_serial = 1'b0;
    ack_mem = 1'b0;
    ack_disk = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total_cnt++;
        if (out_bus !== acv)
          $display("FAIL %s out_bus got %o want %o",
                   nm, out_bus, acv);
        else pass_cnt++;
        total_cnt++;
        if (dev_op !== ins[5:0])
          $display("FAIL %s dev_op got %o want %o",
                   nm, dev_op, ins[5:0]);
        else pass_cnt++;
      end
      obs = {sel_serial, sel_mem, sel_disk};
      if (busy !== (c < exp_len)) busy_err++;
      if (strobe !== (c < L)) strobe_err++;
      if (obs !== ((c < exp_len) ? esel : 3'b000))
        sel_err++;
      if (spur && c < exp_len - 1 &&
          (c == 1 || $urandom_range(0, 3) == 0)) begin
        state = F2;
        instruction = rand_dev_instr();
        ac = 12'($urandom);
      end else begin
        state = F3;
        instruction = 12'o7000;
      end
      q = (k >= 0) && (c == k || (hold && c > k));
      f = foreign;
      ack_serial = (d == 1) ? q : f;
      ack_mem    = (d == 2) ? q : f;
      ack_disk   = (d == 3) ? q : f;
    end
    ack_serial = 1'b0;
    ack_mem = 1'b0;
    ack_disk = 1'b0;
    exp_tmo = exp_tmo | tmo;
    exp_out = acv;
    exp_op = ins[5:0];
    total_cnt++;
    if (busy_err != 0)
      $display("FAIL %s busy_shape got %0d bad want 0 (len %0d)",
               nm, busy_err, exp_len);
    else pass_cnt++;
    total_cnt++;
    if (strobe_err != 0)
      $display("FAIL %s strobe_shape got %0d bad want 0",
               nm, strobe_err);
    else pass_cnt++;
    total_cnt++;
    if (sel_err != 0)
      $display("FAIL %s sel_shape got %0d bad want 0",
               nm, sel_err);
    else pass_cnt++;
    total_cnt++;
    if (out_bus !== exp_out || dev_op !== exp_op)
      $display("FAIL %s hold got %o/%o want %o/%o",
               nm, out_bus, dev_op, exp_out, exp_op);
    else pass_cnt++;
    total_cnt++;
    if (iot_timeout !== exp_tmo)
      $display("FAIL %s iot_timeout got %b want %b",
               nm, iot_timeout, exp_tmo);
    else pass_cnt++;
  endtask

  task automatic test_no_device();
    logic [11:0] list [3];
    int err;
    list[0] = 12'o6034;
    list[1] = 12'o6004;
    list[2] = 12'o6745;
    for (int i = 0; i < 3; i++) begin
      err = 0;
      @(negedge clk);
      state = F2;
      instruction = list[i];
      ac = 12'($urandom);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        state = F3;
        if ({busy, strobe, sel_serial,
             sel_mem, sel_disk} !== 5'd0) err++;
        if (out_bus !== exp_out) err++;
        if (dev_op !== exp_op) err++;
      end
      total_cnt++;
      if (err != 0)
        $display("FAIL nodev_%o got %0d bad want 0",
                 list[i], err);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 12; n++) begin
      k = ($urandom_range(0, 4) == 0) ? -1 :
          int'($urandom_range(0, L + T + 1));
      run_iot("random", rand_dev_instr(),
              12'($urandom), k,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    state = F2;
    instruction = 12'o6743;
    ac = 12'o5252;
    for (int c = 0; c <= L + 1; c++) begin
      @(negedge clk);
      state = F3;
      instruction = 12'o7000;
      if (c == 0) begin
        total_cnt++;
        if (busy !== 1'b1 || sel_disk !== 1'b1)
          $display("FAIL mid_start got %b%b want 11",
                   busy, sel_disk);
        else pass_cnt++;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({out_bus, dev_op} !== 18'd0)
      $display("FAIL mid_reset_data got %o want 0",
               {out_bus, dev_op});
    else pass_cnt++;
    total_cnt++;
    if ({sel_serial, sel_mem, sel_disk,
         strobe, busy, iot_timeout} !== 6'd0)
      $display("FAIL mid_reset_flags got %b want 0",
               {sel_serial, sel_mem, sel_disk,
                strobe, busy, iot_timeout});
    else pass_cnt++;
    reset = 1'b0;
    exp_out = '0;
    exp_op = '0;
    exp_tmo = 1'b0;
  endtask

  initial begin
    test_reset();
    run_iot("serial", 12'o6046, 12'o0101,
            2, 1'b0, 1'b0, 1'b0);
    run_iot("mem", 12'o6221, 12'o1234,
            0, 1'b1, 1'b0, 1'b0);
    run_iot("ack_at_limit", 12'o6747, 12'o7070,
            L + T - 1, 1'b0, 1'b1, 1'b0);
    run_iot("timeout", 12'o6744, 12'o4321,
            -1, 1'b0, 1'b1, 1'b0);
    run_iot("sticky", 12'o6044, 12'o0007,
            1, 1'b0, 1'b0, 1'b0);
    test_no_device();
    run_iot("back_to_back", 12'o6743, 12'o3333,
            4, 1'b0, 1'b0, 1'b1);
    test_random();
    test_reset_mid();
    run_iot("after_reset", 12'o6046, 12'o0777,
            3, 1'b0, 1'b0, 1'b1);
    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
